// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types, constants and width helpers for the PUF evaluation controller
//
// Purpose: FSM state encoding, the fixed LOW phase length and the width
// derivations used by puf_eval_ctrl and puf_bit_vote.
// Ports: none (package).

package puf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  // Cycles start is held low before each evaluation pulse.
  localparam int unsigned LOW_CYCLES = 2;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // A ones-counter must hold 0..repeats inclusive.
  function automatic int unsigned vote_cnt_w(input int unsigned repeats);
    int unsigned w;
    w = clog2(repeats + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Counter width for a counter that counts 0..count-1, never narrower than 1.
  function automatic int unsigned cnt_w(input int unsigned count);
    int unsigned w;
    w = clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/puf_bit_vote.sv
// rtl/puf_bit_vote.sv - per-bit response synchroniser, ones-counter and majority/stability vote
//
// Purpose: one instance per PUF response bit. The asynchronous arbiter output
// is brought into the clk domain with two flops, then counted on each sample
// strobe. Vote outputs are combinational.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   response_i      raw arbiter bit, asynchronous to clk
//   clear_i         zero the ones-counter (new request)
//   sample_i        add the synchronised bit to the ones-counter
//   majority_o      count > REPEATS/2
//   stable_o        count is 0 or REPEATS

module puf_bit_vote
  import puf_pkg::*;
#(
  parameter int unsigned REPEATS = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic response_i,
  input  logic clear_i,
  input  logic sample_i,
  output logic majority_o,
  output logic stable_o
);

  localparam int unsigned CNT_W = vote_cnt_w(REPEATS);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(REPEATS / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(REPEATS);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (sample_i) begin
      cnt_d = cnt_q + CNT_W'(sync_q[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], response_i};
      cnt_q  <= cnt_d;
    end
  end

  // Vote on the next-state count so the final sample, taken on the same edge
  // that enters DONE, is already included when the top registers the result.
  assign majority_o = (cnt_d > HALF);
  assign stable_o   = (cnt_d == '0) || (cnt_d == FULL);

endmodule

// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - arbiter PUF challenge sequencer with repeated evaluation and majority vote
//
// Purpose: accepts a challenge pair, drives the PUF with REPEATS start pulses
// of SETTLE cycles separated by LOW_CYCLES lows, samples the synchronised
// response at the end of each pulse, and returns the majority-voted response
// with a per-bit stability mask.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_challenge1/req_challenge2    challenge operands, N bits each
//   challenge1/challenge2            latched operands to the PUF
//   start                            registered evaluation launch to the PUF
//   response                         2N arbiter outputs, asynchronous to clk
//   rsp_valid/rsp_ready              result handshake
//   rsp_data                         majority-voted response
//   rsp_stable                       bit set when all samples of that bit agreed
//   busy                             high whenever not IDLE

module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned REPEATS = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [N-1:0]   req_challenge1,
  input  logic [N-1:0]   req_challenge2,
  output logic [N-1:0]   challenge1,
  output logic [N-1:0]   challenge2,
  output logic           start,
  input  logic [2*N-1:0] response,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*N-1:0] rsp_data,
  output logic [2*N-1:0] rsp_stable,
  output logic           busy
);

  localparam int unsigned W     = 2 * N;
  localparam int unsigned CYC_W = cnt_w((SETTLE > LOW_CYCLES) ? SETTLE : LOW_CYCLES);
  localparam int unsigned REP_W = cnt_w(REPEATS);

  localparam logic [CYC_W-1:0] LOW_LAST  = CYC_W'(LOW_CYCLES - 1);
  localparam logic [CYC_W-1:0] HIGH_LAST = CYC_W'(SETTLE - 1);
  localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REPEATS - 1);

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [N-1:0]     ch1_q, ch2_q;
  logic             start_q;
  logic             rsp_valid_q;
  logic [W-1:0]     rsp_data_q, rsp_stable_q;

  logic             accept;
  logic             vote_clear;
  logic             vote_sample;
  logic             enter_done;
  logic [W-1:0]     vote_maj;
  logic [W-1:0]     vote_stb;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    rep_d       = rep_q;
    vote_clear  = 1'b0;
    vote_sample = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = LOW;
          cyc_d      = '0;
          rep_d      = '0;
          vote_clear = 1'b1;
        end
      end
      LOW: begin
        if (cyc_q == LOW_LAST) begin
          state_d = HIGH;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      HIGH: begin
        if (cyc_q == HIGH_LAST) begin
          vote_sample = 1'b1;
          cyc_d       = '0;
          if (rep_q == REP_LAST) begin
            state_d = DONE;
          end else begin
            rep_d   = rep_q + 1'b1;
            state_d = LOW;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_done = (state_q == HIGH) && (state_d == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      rep_q        <= '0;
      ch1_q        <= '0;
      ch2_q        <= '0;
      start_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_stable_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      rep_q   <= rep_d;
      if (accept) begin
        ch1_q <= req_challenge1;
        ch2_q <= req_challenge2;
      end
      // Registered from next state so start and rsp_valid are glitch-free and
      // line up with the state they belong to.
      start_q     <= (state_d == HIGH);
      rsp_valid_q <= (state_d == DONE);
      if (enter_done) begin
        rsp_data_q   <= vote_maj;
        rsp_stable_q <= vote_stb;
      end
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_bit
    puf_bit_vote #(
      .REPEATS (REPEATS)
    ) u_vote (
      .clk        (clk),
      .rst        (rst),
      .response_i (response[i]),
      .clear_i    (vote_clear),
      .sample_i   (vote_sample),
      .majority_o (vote_maj[i]),
      .stable_o   (vote_stb[i])
    );
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign challenge1 = ch1_q;
  assign challenge2 = ch2_q;
  assign start      = start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_stable = rsp_stable_q;

endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

- Sequences challenge evaluation for the arbiter PUF array.
- Accepts challenge pairs over a valid/ready request interface and drives the PUF's challenge and start inputs.
- Repeats each evaluation REPEATS times, synchronises the asynchronous arbiter responses, and majority-votes each response bit.
- Returns the voted response plus a per-bit stability mask over a valid/ready result interface; sits directly upstream of and around the PUF array.

## Interface

- N, 4, challenge operand width; response width is 2N
- SETTLE, 16, cycles start is held high per repeat; legal range ≥ 4
- REPEATS, 7, evaluations per request; must be odd, ≥ 1
- clk  in  1  single clock
- rst  in  1  reset; synchronous and active-high
- req_valid  in  1  request challenge pair valid
- req_ready  out  1  block can accept a request
- req_challenge1  in  N  first operand
- req_challenge2  in  N  second operand
- challenge1  out  N  to PUF
- challenge2  out  N  to PUF
- start  out  1  to PUF; launches evaluation while high
- response  in  2N  from PUF arbiters; asynchronous to clk
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  2N  majority-voted response
- rsp_stable  out  2N  bit i = 1 iff all REPEATS samples of bit i agreed
- busy  out  1  high in any state other than IDLE

## Operation

- Request acceptance:
  - A request is accepted on a clk edge where req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - On accept, the challenge operands are latched into challenge1/challenge2, which hold constant until the next accept.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE → LOW on accept. The repeat counter and all per-bit ones-counters clear.
  - LOW: start = 0 for exactly 2 cycles, then → HIGH.
  - HIGH: start = 1 for exactly SETTLE cycles.
    - On the last HIGH cycle, sample the synchronised response and add bit i to ones-counter i.
    - If the repeat counter = REPEATS−1, → DONE; otherwise increment the repeat counter and → LOW.
  - DONE: rsp_valid = 1, with rsp_data and rsp_stable stable. → IDLE on rsp_ready.
- Response synchroniser: each response bit passes through a 2-flop synchroniser, active in all states.
- Vote arithmetic:
  - ones-counter width = clog2(REPEATS+1); counters never overflow.
  - rsp_data[i] = (cnt[i] > REPEATS/2), using integer division.
  - rsp_stable[i] = (cnt[i] == 0) || (cnt[i] == REPEATS).
  - Both are registered on entry to DONE.
- Boundary cases:
  - REPEATS = 1: rsp_stable is all-ones.
  - req_valid while busy: ignored and held off, because req_ready = 0.
  - A rsp_ready pulse outside DONE has no effect.
  - A new request cannot be accepted in the same cycle as the result handshake; it is accepted no earlier than the following cycle.
- Reset (any state, including mid-evaluation), effective on the next edge:
  - FSM → IDLE.
  - start, challenge1, challenge2, rsp_valid, rsp_data, rsp_stable, busy, and all counters → 0.
  - Synchroniser flops → 0.
  - req_ready = 1 from the first cycle after reset.

## Timing

- Acceptance at edge T0 → start rises at T0+3.
- Each repeat lasts 2+SETTLE cycles.
- rsp_valid first observed REPEATS·(2+SETTLE)+1 cycles after T0; this is 127 cycles at the defaults.
- Sample point: the last HIGH cycle. It reflects the response value as it stood 2 cycles earlier, which is why SETTLE ≥ 4.
- start is glitch-free: it is a registered FSM output.
- Throughput: one result per REPEATS·(2+SETTLE)+2 cycles when rsp_ready is held high.

## Structure

- Package puf_pkg holds:
  - the state enum (IDLE, LOW, HIGH, DONE)
  - the LOW_CYCLES = 2 constant
  - the clog2 function
  - the vote-count width derivation
- Sub-module puf_bit_vote: one instance per response bit. Each instance contains:
  - the 2-flop synchroniser
  - the ones-counter, with clear and sample-enable inputs
  - the combinational majority and stable outputs
- The top level holds the FSM, the cycle and repeat counters, the challenge registers and the output registers.

## Test plan

- Reset: hold rst 3 cycles mid-HIGH → next cycle all outputs 0, req_ready = 1, busy = 0.
- Constant stub response 8'hA5, request (4'h3, 4'h5):
  - start shows 7 high pulses of 16 cycles each, separated by 2-cycle lows.
  - rsp_data = 8'hA5 and rsp_stable = 8'hFF, with rsp_valid at T0+127.
- Noisy bit 0, rest of response 0:
  - bit 0 high in 4 of 7 sample windows → rsp_data = 8'h01, rsp_stable = 8'hFE.
  - bit 0 high in 3 of 7 → rsp_data = 8'h00, rsp_stable = 8'hFE.
- Backpressure: rsp_ready low for 20 cycles after rsp_valid, req_valid held high → rsp_valid and rsp_data hold, req_ready stays 0, no second accept.
- Reset during repeat 3 → start = 0 on the next cycle. A fresh request with a constant 8'h3C response returns 8'h3C / 8'hFF with no stale counts.
- Back-to-back requests with rsp_ready = 1 → second accept occurs one cycle after the first result handshake; challenge1/challenge2 change only at that accept.
